// File: rtl/mbus_ice_tx_frame_buf.sv
// mbus_ice_tx_frame_buf
// Single-frame byte buffer in front of the ICE MBus transmit driver. One frame
// is collected from the host decoder, then handed to the driver byte by byte.
// Malformed, overflowed and aborted frames are dropped before the driver sees them.
//
// Optional feature macro: MBUS_ICE_TXBUF_LENCHK_EN
//   defined   : commit only frames with len>=8 and len%4==0 (address word plus
//               whole data words); others are dropped with an err_len pulse.
//   undefined : any frame of 1..DEPTH bytes commits; err_len stays 0.
//
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   wr_valid/wr_data  upstream byte stream, wr_last marks the final byte
//   wr_abort          drop the frame being written (wins over wr_valid)
//   wr_ready          buffer accepts a byte this cycle
//   tx_frame_valid    committed frame has unread bytes
//   tx_char_valid     tx_char holds the next unread byte
//   tx_char           byte at the read pointer (combinational read)
//   tx_char_pending   unread bytes remain in the committed frame
//   tx_char_advance   driver pops the current byte
//   err_len, err_ovf  one-cycle drop pulses (bad length / overflow)
module mbus_ice_tx_frame_buf #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned PTR_W = $clog2(DEPTH + 1)
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       wr_valid,
    input  logic [7:0] wr_data,
    input  logic       wr_last,
    input  logic       wr_abort,
    output logic       wr_ready,
    output logic       tx_frame_valid,
    output logic       tx_char_valid,
    output logic [7:0] tx_char,
    output logic       tx_char_pending,
    input  logic       tx_char_advance,
    output logic       err_len,
    output logic       err_ovf
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_FILL    = 2'd0,
        ST_DISCARD = 2'd1,
        ST_HOLD    = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   len_q, len_d;
    logic               err_len_q, err_len_d;
    logic               err_ovf_q, err_ovf_d;
    logic               wr_ready_q, wr_ready_d;
    logic               hold_q, hold_d;
    logic               mem_we;
    logic [PTR_W-1:0]   len_c;
    logic               len_ok_c;
    logic [7:0]         mem [DEPTH];

    // Length of the frame if the current byte is its last one
    assign len_c = wr_ptr_q + PTR_W'(1);

`ifdef MBUS_ICE_TXBUF_LENCHK_EN
    // len>=8 and len%4==0 is the same as (len-8)%4==0 for len>=8
    assign len_ok_c = (len_c >= PTR_W'(8)) && (len_c[1:0] == 2'b00);
`else
    assign len_ok_c = (len_c != '0);
`endif

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        len_d      = len_q;
        err_len_d  = 1'b0;
        err_ovf_d  = 1'b0;
        mem_we     = 1'b0;

        case (state_q)
            ST_FILL: begin
                if (wr_abort) begin
                    wr_ptr_d = '0;
                end else if (wr_valid) begin
                    if (wr_ptr_q == PTR_W'(DEPTH)) begin
                        // Storage full: drop the frame, swallow the rest of it
                        err_ovf_d = 1'b1;
                        if (wr_last) begin
                            wr_ptr_d = '0;
                        end else begin
                            state_d = ST_DISCARD;
                        end
                    end else begin
                        mem_we   = 1'b1;
                        wr_ptr_d = len_c;
                        if (wr_last) begin
                            if (len_ok_c) begin
                                state_d  = ST_HOLD;
                                rd_ptr_d = '0;
                                len_d    = len_c;
                            end else begin
                                err_len_d = 1'b1;
                                wr_ptr_d  = '0;
                            end
                        end
                    end
                end
            end
            ST_DISCARD: begin
                if (wr_abort || (wr_valid && wr_last)) begin
                    wr_ptr_d = '0;
                    state_d  = ST_FILL;
                end
            end
            ST_HOLD: begin
                if (tx_char_advance && hold_q) begin
                    rd_ptr_d = rd_ptr_q + PTR_W'(1);
                    if (rd_ptr_q == len_q - PTR_W'(1)) begin
                        wr_ptr_d = '0;
                        state_d  = ST_FILL;
                    end
                end
            end
            default: begin
                state_d  = ST_FILL;
                wr_ptr_d = '0;
            end
        endcase

        // Handshake flags follow the next state so they change on the same edge
        hold_d     = (state_d == ST_HOLD);
        wr_ready_d = (state_d != ST_HOLD);
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_FILL;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            len_q      <= '0;
            err_len_q  <= 1'b0;
            err_ovf_q  <= 1'b0;
            wr_ready_q <= 1'b1;
            hold_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            len_q      <= len_d;
            err_len_q  <= err_len_d;
            err_ovf_q  <= err_ovf_d;
            wr_ready_q <= wr_ready_d;
            hold_q     <= hold_d;
        end
    end

    // Frame storage, not reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

    assign wr_ready        = wr_ready_q;
    assign tx_frame_valid  = hold_q;
    assign tx_char_valid   = hold_q;
    assign tx_char_pending = hold_q;
    assign tx_char         = mem[rd_ptr_q[AW-1:0]];
    assign err_len         = err_len_q;
    assign err_ovf         = err_ovf_q;

endmodule

// File: tb/tb_mbus_ice_tx_frame_buf.sv
// Scoreboard bench for mbus_ice_tx_frame_buf: the write driver pushes the
// bytes each committed frame must produce; a consumer pops with a configurable
// stall; a monitor compares every popped byte and the handshake flags.
module tb_mbus_ice_tx_frame_buf;

    logic       clk;
    logic       reset_n;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_last;
    logic       wr_abort;
    logic       wr_ready;
    logic       tx_frame_valid;
    logic       tx_char_valid;
    logic [7:0] tx_char;
    logic       tx_char_pending;
    logic       tx_char_advance;
    logic       err_len;
    logic       err_ovf;

    mbus_ice_tx_frame_buf #(.DEPTH(64)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .wr_valid        (wr_valid),
        .wr_data         (wr_data),
        .wr_last         (wr_last),
        .wr_abort        (wr_abort),
        .wr_ready        (wr_ready),
        .tx_frame_valid  (tx_frame_valid),
        .tx_char_valid   (tx_char_valid),
        .tx_char         (tx_char),
        .tx_char_pending (tx_char_pending),
        .tx_char_advance (tx_char_advance),
        .err_len         (err_len),
        .err_ovf         (err_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         vectors     = 0;
    int         miscompares = 0;
    logic [7:0] exp_q[$];
    logic [7:0] fb [0:127];
    int         gap_cycles  = 0;
    int         pop_budget  = -1;
    int         wait_cnt    = 0;
    int         err_len_seen = 0;
    int         err_ovf_seen = 0;
    logic       prev_valid  = 1'b0;
    logic       prev_pop    = 1'b0;
    logic [7:0] prev_char   = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Consumer: pops the presented byte after gap_cycles idle cycles
    initial begin
        tx_char_advance = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (tx_char_valid && pop_budget != 0) begin
                if (wait_cnt >= gap_cycles) begin
                    tx_char_advance = 1'b1;
                    wait_cnt = 0;
                    if (pop_budget > 0) pop_budget--;
                end else begin
                    tx_char_advance = 1'b0;
                    wait_cnt++;
                end
            end else begin
                tx_char_advance = 1'b0;
                wait_cnt = 0;
            end
        end
    end

    // Monitor: flags, hold stability, popped bytes against the scoreboard
    always @(negedge clk) begin
        if (reset_n) begin
            if (err_len) err_len_seen++;
            if (err_ovf) err_ovf_seen++;
            chk("flags", 32'({tx_frame_valid, tx_char_pending, wr_ready}),
                tx_char_valid ? 32'h6 : 32'h1);
            if (tx_char_valid && prev_valid && !prev_pop)
                chk("hold_stable", 32'(tx_char), 32'(prev_char));
            if (tx_char_valid && tx_char_advance) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_pop: got %0h expected no byte", tx_char);
                end else begin
                    chk("tx_char", 32'(tx_char), 32'(exp_q.pop_front()));
                end
            end
            prev_valid = tx_char_valid;
            prev_char  = tx_char;
            prev_pop   = tx_char_valid && tx_char_advance;
        end else begin
            prev_valid = 1'b0;
            prev_pop   = 1'b0;
        end
    end

    // Write one frame from fb[0..n-1]; checks error pulses after every edge
    task automatic send_frame(input int n, input bit commit, input int ovf_idx,
                              input bit len_err, input int abort_idx);
        if (commit) for (int i = 0; i < n; i++) exp_q.push_back(fb[i]);
        for (int i = 0; i < n; i++) begin
            int t = 0;
            while (!wr_ready && t < 100) begin
                @(negedge clk);
                t++;
            end
            if (!wr_ready) chk("wr_ready_timeout", 32'(wr_ready), 32'h1);
            wr_valid = 1'b1;
            wr_data  = fb[i];
            wr_last  = (i == n - 1);
            wr_abort = (i == abort_idx);
            @(posedge clk);
            @(negedge clk);
            wr_valid = 1'b0;
            wr_last  = 1'b0;
            wr_abort = 1'b0;
            chk("err_ovf", 32'(err_ovf), 32'(i == ovf_idx));
            chk("err_len", 32'(err_len), 32'(len_err && (i == n - 1)));
            if (i == abort_idx) break;
        end
        chk("commit", 32'(tx_frame_valid), 32'(commit));
    endtask

    // Wait for the scoreboard to empty, then check the buffer released
    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 400) begin
            @(posedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            chk("drain_timeout", 32'(exp_q.size()), 32'h0);
            exp_q.delete();
        end
        @(negedge clk);
        chk("release_valid", 32'(tx_frame_valid), 32'h0);
        chk("release_ready", 32'(wr_ready), 32'h1);
    endtask

    initial begin
        reset_n  = 1'b0;
        wr_valid = 1'b0;
        wr_data  = 8'h00;
        wr_last  = 1'b0;
        wr_abort = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(wr_ready), 32'h1);
        chk("rst_tx", 32'({tx_frame_valid, tx_char_valid, tx_char_pending}), 32'h0);
        chk("rst_err", 32'({err_len, err_ovf}), 32'h0);

        // 8-byte frame, back-to-back pops
        fb[0] = 8'h01; fb[1] = 8'h02; fb[2] = 8'h03; fb[3] = 8'h04;
        fb[4] = 8'hAA; fb[5] = 8'hBB; fb[6] = 8'hCC; fb[7] = 8'hDD;
        gap_cycles = 0;
        send_frame(8, 1'b1, -1, 1'b0, -1);
        drain();

        // 12-byte frame, consumer stalls 3 cycles between pops
        for (int i = 0; i < 12; i++) fb[i] = 8'(8'h40 + i);
        gap_cycles = 3;
        send_frame(12, 1'b1, -1, 1'b0, -1);
        drain();
        gap_cycles = 0;

        // 10-byte frame: dropped only when the length check is built in
        for (int i = 0; i < 10; i++) fb[i] = 8'(8'h30 + i);
`ifdef MBUS_ICE_TXBUF_LENCHK_EN
        send_frame(10, 1'b0, -1, 1'b1, -1);
        repeat (3) @(negedge clk);
        chk("len_drop_valid", 32'(tx_frame_valid), 32'h0);
`else
        send_frame(10, 1'b1, -1, 1'b0, -1);
        drain();
`endif

        // 70-byte overflow frame, then a clean 8-byte frame
        for (int i = 0; i < 70; i++) fb[i] = 8'(8'h80 + i);
        send_frame(70, 1'b0, 64, 1'b0, -1);
        repeat (3) @(negedge clk);
        chk("ovf_drop_valid", 32'(tx_frame_valid), 32'h0);
        for (int i = 0; i < 8; i++) fb[i] = 8'(8'hE0 + i);
        send_frame(8, 1'b1, -1, 1'b0, -1);
        drain();

        // Abort on the 5th byte, then a clean frame
        for (int i = 0; i < 8; i++) fb[i] = 8'(8'h90 + i);
        send_frame(8, 1'b0, -1, 1'b0, 4);
        for (int i = 0; i < 8; i++) fb[i] = 8'(8'h50 + i);
        send_frame(8, 1'b1, -1, 1'b0, -1);
        drain();

        // Reset after 3 of 8 bytes are read out
        for (int i = 0; i < 8; i++) fb[i] = 8'(8'h60 + i);
        pop_budget = 3;
        send_frame(8, 1'b1, -1, 1'b0, -1);
        begin
            int t = 0;
            while (exp_q.size() != 5 && t < 100) begin
                @(posedge clk);
                t++;
            end
        end
        @(negedge clk);
        chk("pre_reset_valid", 32'(tx_char_valid), 32'h1);
        chk("pre_reset_char", 32'(tx_char), 32'h63);
        reset_n = 1'b0;
        #1;
        chk("reset_tx", 32'({tx_frame_valid, tx_char_valid, tx_char_pending}), 32'h0);
        exp_q.delete();
        pop_budget = -1;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_reset_ready", 32'(wr_ready), 32'h1);
        for (int i = 0; i < 8; i++) fb[i] = 8'(8'h70 + i);
        send_frame(8, 1'b1, -1, 1'b0, -1);
        drain();

        // Total error pulses across the run
`ifdef MBUS_ICE_TXBUF_LENCHK_EN
        chk("err_len_total", 32'(err_len_seen), 32'h1);
`else
        chk("err_len_total", 32'(err_len_seen), 32'h0);
`endif
        chk("err_ovf_total", 32'(err_ovf_seen), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Watchdog
    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: got no end of test expected finish within 20000 cycles");
        $fatal(1, "watchdog expired");
    end

endmodule
